// File: rtl/de_stage_reg.sv
// de_stage_reg: decode/execute pipeline register.
// Captures the decoded instruction and its register-file operands.
// Operands written back in the same cycle bypass the register file.
// On exec_stall the stage holds its contents. save_mw_reg_rs1/rs2 can
// still overwrite a held operand with the writeback value.
// A flush kills the held instruction.
// Optional: define DE_STAGE_PERF_EN to add the saturating stall_cycles and
// bubble_cycles counters.
module de_stage_reg #(
  parameter int word_width     = 32,
  parameter int reg_addr_width = 5,
  parameter int op_width       = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic [reg_addr_width-1:0] dec_rs1_tag,
  input  logic [reg_addr_width-1:0] dec_rs2_tag,
  input  logic                      dec_rs1_valid,
  input  logic                      dec_rs2_valid,
  input  logic [reg_addr_width-1:0] dec_rd_tag,
  input  logic                      dec_rd_valid,
  input  logic [word_width-1:0]     dec_imm,
  input  logic [op_width-1:0]       dec_op,
  input  logic [word_width-1:0]     dec_pc,
  input  logic [word_width-1:0]     rf_rs1_data,
  input  logic [word_width-1:0]     rf_rs2_data,
  input  logic [word_width-1:0]     reg_wr_data,
  input  logic [reg_addr_width-1:0] reg_wr_data_tag,
  input  logic                      reg_wr_data_valid,
  input  logic                      exec_stall,
  input  logic                      save_mw_reg_rs1,
  input  logic                      save_mw_reg_rs2,
  input  logic                      flush,
  output logic                      de_reg_valid,
  output logic [word_width-1:0]     de_reg_rs1_data,
  output logic [word_width-1:0]     de_reg_rs2_data,
  output logic [reg_addr_width-1:0] de_reg_rs1_tag,
  output logic [reg_addr_width-1:0] de_reg_rs2_tag,
  output logic                      de_reg_rs1_valid,
  output logic                      de_reg_rs2_valid,
  output logic [reg_addr_width-1:0] de_reg_rd_tag,
  output logic                      de_reg_rd_valid,
  output logic [word_width-1:0]     de_reg_imm,
  output logic [op_width-1:0]       de_reg_op,
  output logic [word_width-1:0]     de_reg_pc
`ifdef DE_STAGE_PERF_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               bubble_cycles
`endif
);

  logic [word_width-1:0] rs1_capture;
  logic [word_width-1:0] rs2_capture;
  logic                  advance;

  // Accept when not stalled, or when a flush drops the incoming wrong-path instruction.
  assign dec_ready = !rst && (flush || !exec_stall);
  assign advance   = !rst && !flush && !exec_stall;

  // Operand selection: x0 reads zero; same-cycle writeback beats stale register-file data.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    rs1_capture = rf_rs1_data;
    rs2_capture = rf_rs2_data;
    if (dec_rs1_tag == '0)
      rs1_capture = '0;
    else if (reg_wr_data_valid && dec_rs1_valid && (reg_wr_data_tag == dec_rs1_tag))
      rs1_capture = reg_wr_data;
    if (dec_rs2_tag == '0)
      rs2_capture = '0;
    else if (reg_wr_data_valid && dec_rs2_valid && (reg_wr_data_tag == dec_rs2_tag))
      rs2_capture = reg_wr_data;
  end

  // Stage register: reset, flush, stall (with operand save), advance or bubble, in priority order.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every field samples pre-edge values.
    if (rst) begin
      de_reg_valid     <= 1'b0;
      de_reg_rs1_data  <= '0;
      de_reg_rs2_data  <= '0;
      de_reg_rs1_tag   <= '0;
      de_reg_rs2_tag   <= '0;
      de_reg_rs1_valid <= 1'b0;
      de_reg_rs2_valid <= 1'b0;
      de_reg_rd_tag    <= '0;
      de_reg_rd_valid  <= 1'b0;
      de_reg_imm       <= '0;
      de_reg_op        <= '0;
      de_reg_pc        <= '0;
    end else if (flush) begin
      de_reg_valid    <= 1'b0;
      de_reg_rd_valid <= 1'b0;
    end else if (exec_stall) begin
      if (save_mw_reg_rs1) de_reg_rs1_data <= reg_wr_data;
      if (save_mw_reg_rs2) de_reg_rs2_data <= reg_wr_data;
    end else if (dec_valid) begin
      de_reg_valid     <= 1'b1;
      de_reg_rs1_data  <= rs1_capture;
      de_reg_rs2_data  <= rs2_capture;
      de_reg_rs1_tag   <= dec_rs1_tag;
      de_reg_rs2_tag   <= dec_rs2_tag;
      de_reg_rs1_valid <= dec_rs1_valid;
      de_reg_rs2_valid <= dec_rs2_valid;
      de_reg_rd_tag    <= dec_rd_tag;
      de_reg_rd_valid  <= dec_rd_valid;
      de_reg_imm       <= dec_imm;
      de_reg_op        <= dec_op;
      de_reg_pc        <= dec_pc;
    end else begin
      de_reg_valid    <= 1'b0;
      de_reg_rd_valid <= 1'b0;
    end
  end

`ifdef DE_STAGE_PERF_EN
  // Saturating counts of stalled-valid cycles and bubble advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (!flush && exec_stall && de_reg_valid && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (advance && !dec_valid && (bubble_cycles != '1))
        bubble_cycles <= bubble_cycles + 32'd1;
    end
  end
`endif

endmodule
